// File: rtl/csa_resolver.sv
// csa_resolver: iterative carry-save to binary resolver.
// Applies one half-adder step per cycle until the carry vector is zero.
module csa_resolver #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result,
    output logic [CW-1:0]    out_steps
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [WIDTH:0] s;
    logic [WIDTH:0] c;
    logic [CW-1:0]  cnt;
    logic           load;
    logic           step;
    logic           latch;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes; abort overrides everything
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        latch      = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (c == '0) begin
                        latch      = 1'b1;
                        state_next = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Redundant pair, step counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s          <= '0;
            c          <= '0;
            cnt        <= '0;
            out_result <= '0;
            out_steps  <= '0;
        end else begin
            if (abort) begin
                cnt <= '0;
            end else if (load) begin
                s   <= {1'b0, in_sum};
                c   <= {1'b0, in_carry};
                cnt <= '0;
            end else if (step) begin
                // s+c is invariant; the true sum fits WIDTH+1 bits so
                // the shifted-out MSB is always zero.
                s   <= s ^ c;
                c   <= (s & c) << 1;
                cnt <= cnt + CW'(1);
            end
            if (latch) begin
                out_result <= s;
                out_steps  <= cnt;
            end
        end
    end

endmodule
